mips_multicycle_controller: RTL and testbench

- Main control FSM for the multicycle MIPS datapath. Sequences one shared ALU, register file and unified instruction/data memory across fetch, decode, execute, memory and writeback steps.
- Decodes Op/Funct into per-state datapath enables and the 3-bit ALU control code.
- Stalls on a memory ready handshake.
- Sits beside the datapath; the only arbitration is cycle-by-cycle reuse of the ALU and memory.

---
 rtl/mips_multicycle_controller.sv | 205 ++++++++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath: state sequencing, datapath enables, ALU control.
// Optional bne support is enabled by defining MIPS_CTRL_BNE_EN.
module mips_multicycle_controller #(
  parameter int RESET_PC_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT} aluop_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  state_t     state, state_nxt;
  logic [3:0] hold_cnt;
  logic       alu_en;
  aluop_t     aluop;

`ifdef MIPS_CTRL_BNE_EN
  logic       bne_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      hold_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= (state == S_IDLE) ? hold_cnt + 4'd1 : 4'd0;
    end
  end

`ifdef MIPS_CTRL_BNE_EN
  // Branch flavour is captured while the opcode is known valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 bne_q <= 1'b0;
    else if (state == S_DECODE) bne_q <= (Op == OP_BNE);
  end
`endif

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    PCEn      = 1'b0;
    Illegal   = 1'b0;
    alu_en    = 1'b0;
    aluop     = ALU_ADD;

    unique case (state)
      S_IDLE: begin
        if (hold_cnt == 4'(RESET_PC_HOLD - 1)) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        MemReq  = 1'b1;
        ALUSrcB = 2'b01;
        alu_en  = 1'b1;
        IRWrite = MemReady;
        PCEn    = MemReady;
        if (MemReady) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        alu_en  = 1'b1;
        case (Op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYP:      state_nxt = S_EXECUTE;
          OP_BEQ:       state_nxt = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       state_nxt = S_BRANCH;
`endif
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JUMP;
          default: begin
            Illegal   = 1'b1;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        alu_en    = 1'b1;
        state_nxt = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        if (MemReady) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        MemReq   = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) state_nxt = S_FETCH;
      end
      S_EXECUTE: begin
        ALUSrcA   = 1'b1;
        alu_en    = 1'b1;
        aluop     = ALU_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        alu_en    = 1'b1;
        aluop     = ALU_SUB;
        PCSrc     = 2'b01;
`ifdef MIPS_CTRL_BNE_EN
        PCEn      = bne_q ? ~Zero : Zero;
`else
        PCEn      = Zero;
`endif
        state_nxt = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        alu_en    = 1'b1;
        state_nxt = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        PCSrc     = 2'b10;
        PCEn      = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ALU code stays 000 in states that do not use the ALU.
  always_comb begin
    ALUControl = 3'b000;
    if (alu_en) begin
      unique case (aluop)
        ALU_ADD: ALUControl = 3'b010;
        ALU_SUB: ALUControl = 3'b110;
        default: begin
          case (Funct)
            6'b100000: ALUControl = 3'b010;
            6'b100010: ALUControl = 3'b110;
            6'b100100: ALUControl = 3'b000;
            6'b100101: ALUControl = 3'b001;
            6'b101010: ALUControl = 3'b111;
            default:   ALUControl = 3'b010;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Scoreboard bench for mips_multicycle_controller: per-cycle expected output vectors are queued
// by the stimulus process and compared by a monitor on the falling edge.
module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       MemReq, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       PCEn, Illegal;

  mips_multicycle_controller #(.RESET_PC_HOLD(1)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [16:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  logic [16:0] act;
  assign act = {MemReq, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUControl, PCSrc, PCEn, Illegal};

  // Field order: MemReq MemWrite IorD IRWrite RegDst MemtoReg RegWrite ALUSrcA ALUSrcB ALUControl PCSrc PCEn Illegal
  function automatic logic [16:0] mk(input logic mreq, mwr, iord, irw, rdst, m2r, rw, srca,
                                     input logic [1:0] srcb, input logic [2:0] ctl,
                                     input logic [1:0] pcs, input logic pcen, ill);
    return {mreq, mwr, iord, irw, rdst, m2r, rw, srca, srcb, ctl, pcs, pcen, ill};
  endfunction

  localparam logic [16:0] E_ZERO = 17'd0;
  function automatic logic [16:0] e_fetch(input logic mr);
    return mk(1,0,0,mr,0,0,0,0,2'b01,3'b010,2'b00,mr,0);
  endfunction
  function automatic logic [16:0] e_decode(input logic ill);
    return mk(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,ill);
  endfunction
  function automatic logic [16:0] e_memadr();
    return mk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
  endfunction
  function automatic logic [16:0] e_memrd();
    return mk(1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0);
  endfunction
  function automatic logic [16:0] e_memwb();
    return mk(0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,0);
  endfunction
  function automatic logic [16:0] e_memwr();
    return mk(1,1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0);
  endfunction
  function automatic logic [16:0] e_exec(input logic [2:0] ctl);
    return mk(0,0,0,0,0,0,0,1,2'b00,ctl,2'b00,0,0);
  endfunction
  function automatic logic [16:0] e_aluwb();
    return mk(0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0,0);
  endfunction
  function automatic logic [16:0] e_branch(input logic pcen);
    return mk(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,pcen,0);
  endfunction
  function automatic logic [16:0] e_addiwb();
    return mk(0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,0);
  endfunction
  function automatic logic [16:0] e_jump();
    return mk(0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,0);
  endfunction

  // Monitor: the controller presents a full output vector every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s: got %05h expected %05h", e.name, act, e.v);
      end
    end
  end

  // Drive inputs for one cycle, queue the expected outputs, advance to just after the next edge.
  task automatic step(input string name, input logic mr, input logic z, input logic [16:0] e);
    exp_t x;
    MemReady = mr;
    Zero     = z;
    x.name   = name;
    x.v      = e;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn);
    Op    = op;
    Funct = fn;
    step("fetch", 1, 0, e_fetch(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step("reset", 1, 1, E_ZERO);
    rst_n = 1'b1;
    step("idle", 1, 1, E_ZERO);

    // lw, no stalls: 5 cycles
    instr(6'b100011, 6'd0);
    step("lw_decode", 1, 0, e_decode(0));
    step("lw_memadr", 0, 0, e_memadr());
    step("lw_memrd", 1, 0, e_memrd());
    step("lw_memwb", 0, 1, e_memwb());

    // lw with one read stall
    instr(6'b100011, 6'd0);
    step("lw2_decode", 1, 0, e_decode(0));
    step("lw2_memadr", 1, 0, e_memadr());
    step("lw2_memrd_stall", 0, 0, e_memrd());
    step("lw2_memrd", 1, 0, e_memrd());
    step("lw2_memwb", 1, 0, e_memwb());

    // sw with two write stalls
    instr(6'b101011, 6'd0);
    step("sw_decode", 1, 0, e_decode(0));
    step("sw_memadr", 1, 0, e_memadr());
    step("sw_memwr_stall1", 0, 0, e_memwr());
    step("sw_memwr_stall2", 0, 0, e_memwr());
    step("sw_memwr", 1, 0, e_memwr());

    // R-type variants
    instr(6'b000000, 6'b101010);
    step("slt_decode", 1, 0, e_decode(0));
    step("slt_exec", 0, 1, e_exec(3'b111));
    step("slt_aluwb", 0, 0, e_aluwb());
    instr(6'b000000, 6'b100100);
    step("and_decode", 1, 0, e_decode(0));
    step("and_exec", 1, 0, e_exec(3'b000));
    step("and_aluwb", 1, 0, e_aluwb());
    instr(6'b000000, 6'b100101);
    step("or_decode", 1, 0, e_decode(0));
    step("or_exec", 1, 0, e_exec(3'b001));
    step("or_aluwb", 1, 0, e_aluwb());
    instr(6'b000000, 6'b100010);
    step("sub_decode", 1, 0, e_decode(0));
    step("sub_exec", 1, 0, e_exec(3'b110));
    step("sub_aluwb", 1, 0, e_aluwb());
    instr(6'b000000, 6'b111111);
    step("badfn_decode", 1, 0, e_decode(0));
    step("badfn_exec", 1, 0, e_exec(3'b010));
    step("badfn_aluwb", 1, 0, e_aluwb());

    // addi
    instr(6'b001000, 6'd0);
    step("addi_decode", 1, 0, e_decode(0));
    step("addi_ex", 1, 0, e_memadr());
    step("addi_wb", 1, 0, e_addiwb());

    // beq taken / not taken
    instr(6'b000100, 6'd0);
    step("beq_decode", 1, 0, e_decode(0));
    step("beq_taken", 0, 1, e_branch(1));
    instr(6'b000100, 6'd0);
    step("beq2_decode", 1, 1, e_decode(0));
    step("beq_nottaken", 1, 0, e_branch(0));

    // jump
    instr(6'b000010, 6'd0);
    step("j_decode", 1, 0, e_decode(0));
    step("j_jump", 0, 0, e_jump());

    // unsupported opcode
    instr(6'b111111, 6'd0);
    step("ill_decode", 1, 0, e_decode(1));

`ifdef MIPS_CTRL_BNE_EN
    instr(6'b000101, 6'd0);
    step("bne_decode", 1, 0, e_decode(0));
    step("bne_taken", 1, 0, e_branch(1));
    instr(6'b000101, 6'd0);
    step("bne2_decode", 1, 0, e_decode(0));
    step("bne_nottaken", 1, 1, e_branch(0));
`else
    instr(6'b000101, 6'd0);
    step("bne_illegal", 1, 0, e_decode(1));
`endif

    // Fetch stall interrupted by reset: outputs must clear without a clock edge.
    Op = 6'b000010;
    step("fstall1", 0, 0, e_fetch(0));
    step("fstall2", 0, 0, e_fetch(0));
    rst_n = 1'b0;
    step("fstall_reset_async", 0, 0, E_ZERO);
    step("fstall_reset_hold", 0, 0, E_ZERO);
    rst_n = 1'b1;
    step("post_reset_idle", 1, 0, E_ZERO);
    instr(6'b000010, 6'd0);
    step("post_reset_decode", 1, 0, e_decode(0));
    step("post_reset_jump", 1, 0, e_jump());
    step("post_reset_fetch", 0, 0, e_fetch(0));

    @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
